// File: rtl/jacobi_pivot_sequencer_if.sv
// Bus bundle between the Jacobi pivot sequencer, the matrix register file
// read port and the rotation datapath. The sequencer takes the master side.
//
// Rotation handshake: rot_valid_out is raised by the sequencer with
// rot_p_out/rot_q_out already stable. Both stay unchanged until a rising
// clock edge samples rot_valid_out && rot_ready_in. That edge is the
// transfer, and rot_valid_out is low from the following cycle. The rotation
// unit may hold rot_ready_in high or low at any time. rot_done_in is a
// separate one-cycle completion pulse and is not part of the handshake.
interface jacobi_pivot_sequencer_if #(
  parameter int WIDTH    = 16,
  parameter int N_STOCKS = 4,
  parameter int MAX_ITER = 32
);
  localparam int AW = $clog2(N_STOCKS);
  localparam int CW = $clog2(MAX_ITER + 1);

  // run control
  logic             start_in;
  logic [WIDTH-1:0] threshold_in;
  // matrix read port (data one cycle after the request)
  logic             rd_en_out;
  logic [AW-1:0]    rd_i_out;
  logic [AW-1:0]    rd_j_out;
  logic [WIDTH-1:0] rd_data_in;
  // rotation request
  logic             rot_valid_out;
  logic             rot_ready_in;
  logic [AW-1:0]    rot_p_out;
  logic [AW-1:0]    rot_q_out;
  logic             rot_done_in;
  // status
  logic             busy_out;
  logic             done_out;
  logic             converged_out;
  logic [CW-1:0]    iter_count_out;
  // current FSM state, for checkers and debug
  logic [2:0]       state_dbg;

  modport master (
    input  start_in, threshold_in, rd_data_in, rot_ready_in, rot_done_in,
    output rd_en_out, rd_i_out, rd_j_out, rot_valid_out, rot_p_out, rot_q_out,
           busy_out, done_out, converged_out, iter_count_out, state_dbg
  );

  modport slave (
    output start_in, threshold_in, rd_data_in, rot_ready_in, rot_done_in,
    input  rd_en_out, rd_i_out, rd_j_out, rot_valid_out, rot_p_out, rot_q_out,
           busy_out, done_out, converged_out, iter_count_out, state_dbg
  );
endinterface

// File: rtl/jacobi_pivot_sequencer.sv
// Jacobi pivot sequencer: repeatedly scans the upper triangle of the
// covariance matrix, picks the largest-magnitude off-diagonal element and
// issues it as a rotation request until the pivot is within threshold or
// the rotation budget is used up.
module jacobi_pivot_sequencer #(
  parameter int WIDTH    = 16,
  parameter int N_STOCKS = 4,
  parameter int MAX_ITER = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  jacobi_pivot_sequencer_if.master bus
);

  localparam int AW = $clog2(N_STOCKS);
  localparam int CW = $clog2(MAX_ITER + 1);
  localparam int P  = N_STOCKS * (N_STOCKS - 1) / 2;
  localparam int SW = $clog2(P + 1);

  localparam logic [SW-1:0] SCAN_LAST  = SW'(P);
  localparam logic [SW-1:0] ISSUE_LAST = SW'(P - 1);
  localparam logic [AW-1:0] COL_LAST   = AW'(N_STOCKS - 1);
  localparam logic [CW-1:0] ITER_LIMIT = CW'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_DECIDE = 3'd2,
    S_ROTATE = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [SW-1:0]    scan_cnt;
  logic [AW-1:0]    addr_i, addr_j;
  logic             rd_pend;
  logic [AW-1:0]    ret_i, ret_j;
  logic [WIDTH-1:0] data_mag;
  logic [WIDTH-1:0] max_mag;
  logic [AW-1:0]    piv_i, piv_j;
  logic [WIDTH-1:0] thr;
  logic [AW-1:0]    rot_p, rot_q;
  logic [CW-1:0]    iter_cnt;
  logic             converged;

  logic issue;
  logic start_acc;
  logic scan_enter;
  logic pivot_small;
  logic budget_spent;

  // A read is issued in each of the first P SCAN cycles; the last SCAN
  // cycle only absorbs the final returned datum.
  assign issue        = (state == S_SCAN) && (scan_cnt <= ISSUE_LAST);
  assign start_acc    = (state == S_IDLE) && bus.start_in;
  assign scan_enter   = start_acc || ((state == S_WAIT) && bus.rot_done_in);
  assign pivot_small  = (max_mag <= thr);
  assign budget_spent = (iter_cnt == ITER_LIMIT);

  // |x| as an unsigned WIDTH-bit value; the most negative code maps to
  // 2^(WIDTH-1) naturally through the two's complement negate.
  assign data_mag = bus.rd_data_in[WIDTH-1] ? (~bus.rd_data_in + WIDTH'(1))
                                            : bus.rd_data_in;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.start_in) state_nx = S_SCAN;
      S_SCAN:   if (scan_cnt == SCAN_LAST) state_nx = S_DECIDE;
      S_DECIDE: state_nx = (pivot_small || budget_spent) ? S_DONE : S_ROTATE;
      S_ROTATE: if (bus.rot_ready_in) state_nx = S_WAIT;
      S_WAIT:   if (bus.rot_done_in) state_nx = S_SCAN;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Scan cycle counter and row-major upper-triangle address walk
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scan_cnt <= '0;
      addr_i   <= '0;
      addr_j   <= '0;
    end else if (scan_enter) begin
      scan_cnt <= '0;
      addr_i   <= '0;
      addr_j   <= AW'(1);
    end else if (state == S_SCAN) begin
      if (scan_cnt != SCAN_LAST) scan_cnt <= scan_cnt + SW'(1);
      if (issue) begin
        if (scan_cnt == ISSUE_LAST) begin
          addr_i <= '0;
          addr_j <= '0;
        end else if (addr_j == COL_LAST) begin
          addr_i <= addr_i + AW'(1);
          addr_j <= addr_i + AW'(2);
        end else begin
          addr_j <= addr_j + AW'(1);
        end
      end
    end
  end

  // Remember which pair each outstanding read belongs to
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_pend <= 1'b0;
      ret_i   <= '0;
      ret_j   <= '0;
    end else begin
      rd_pend <= issue;
      if (issue) begin
        ret_i <= addr_i;
        ret_j <= addr_j;
      end
    end
  end

  // Running maximum; strict compare keeps the earliest pair on ties
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      max_mag <= '0;
      piv_i   <= '0;
      piv_j   <= '0;
    end else if (scan_enter) begin
      max_mag <= '0;
      piv_i   <= '0;
      piv_j   <= AW'(1);
    end else if ((state == S_SCAN) && rd_pend && (data_mag > max_mag)) begin
      max_mag <= data_mag;
      piv_i   <= ret_i;
      piv_j   <= ret_j;
    end
  end

  // Run bookkeeping: threshold, iteration count, outcome and issued pivot
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      thr       <= '0;
      iter_cnt  <= '0;
      converged <= 1'b0;
      rot_p     <= '0;
      rot_q     <= '0;
    end else begin
      if (start_acc) begin
        thr       <= bus.threshold_in;
        iter_cnt  <= '0;
        converged <= 1'b0;
      end
      if (state == S_DECIDE) begin
        if (pivot_small) begin
          converged <= 1'b1;
        end else if (!budget_spent) begin
          rot_p <= piv_i;
          rot_q <= piv_j;
        end
      end
      if ((state == S_WAIT) && bus.rot_done_in) iter_cnt <= iter_cnt + CW'(1);
    end
  end

  // Outputs decode straight from the state flop so reset clears them at once
  assign bus.rd_en_out      = issue;
  assign bus.rd_i_out       = addr_i;
  assign bus.rd_j_out       = addr_j;
  assign bus.rot_valid_out  = (state == S_ROTATE);
  assign bus.rot_p_out      = rot_p;
  assign bus.rot_q_out      = rot_q;
  assign bus.busy_out       = (state == S_SCAN) || (state == S_DECIDE) ||
                              (state == S_ROTATE) || (state == S_WAIT);
  assign bus.done_out       = (state == S_DONE);
  assign bus.converged_out  = converged;
  assign bus.iter_count_out = iter_cnt;
  assign bus.state_dbg      = state;

endmodule

// File: tb/tb_jacobi_pivot_sequencer.sv
// Bench for jacobi_pivot_sequencer: a registered matrix read port, a pivot
// search model over the whole triangle, directed and randomized runs.
module tb_jacobi_pivot_sequencer;

  localparam int WIDTH    = 16;
  localparam int N        = 4;
  localparam int MAX_ITER = 3;
  localparam int P        = N * (N - 1) / 2;
  localparam int AW       = $clog2(N);
  localparam int W        = 2 * AW;

  logic clk;
  logic rst;

  jacobi_pivot_sequencer_if #(.WIDTH(WIDTH), .N_STOCKS(N), .MAX_ITER(MAX_ITER)) bus ();

  jacobi_pivot_sequencer #(.WIDTH(WIDTH), .N_STOCKS(N), .MAX_ITER(MAX_ITER)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- matrix storage model ----------------
  logic signed [WIDTH-1:0] mat     [N][N];
  logic signed [WIDTH-1:0] model_m [N][N];

  // Registered read port; returns noise when not read so stray use shows up
  always @(posedge clk) begin
    if (bus.rd_en_out) bus.rd_data_in <= mat[bus.rd_i_out][bus.rd_j_out];
    else               bus.rd_data_in <= WIDTH'($urandom);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit           exp_conv;
  int           exp_iter;
  int           pair_i[P];
  int           pair_j[P];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_mat();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mat[i][j] = '0;
  endtask

  task automatic set_elem(input int i, input int j, input int v);
    mat[i][j] = WIDTH'(v);
    mat[j][i] = WIDTH'(v);
  endtask

  // Largest |a[p][q]| over the upper triangle, first one in row-major order
  task automatic find_pivot(output int bp, output int bq, output int bmag);
    int v, mg;
    bp = 0; bq = 1; bmag = 0;
    for (int p = 0; p < N - 1; p++)
      for (int q = p + 1; q < N; q++) begin
        v  = int'(model_m[p][q]);
        mg = (v < 0) ? -v : v;
        if (mg > bmag) begin bp = p; bq = q; bmag = mg; end
      end
  endtask

  // Whole-run expectation: list of pivots, outcome, final rotation count
  task automatic build_expect(input logic [WIDTH-1:0] thr, input bit zero_on_done);
    int bp, bq, bmag, n;
    model_m = mat;
    exp_q.delete();
    n = 0;
    forever begin
      find_pivot(bp, bq, bmag);
      if (bmag <= int'(thr)) begin exp_conv = 1'b1; break; end
      if (n == MAX_ITER)     begin exp_conv = 1'b0; break; end
      exp_q.push_back({AW'(bp), AW'(bq)});
      if (zero_on_done) model_m[bp][bq] = '0;
      n++;
    end
    exp_iter = n;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [WIDTH-1:0] thr);
    bus.start_in     = 1'b1;
    bus.threshold_in = thr;
    @(posedge clk); #1;
    bus.start_in     = 1'b0;
    bus.threshold_in = WIDTH'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rot_valid"}, bus.rot_valid_out, 0);
    check({tag, "_busy"},      bus.busy_out, 0);
    check({tag, "_done"},      bus.done_out, 0);
    check({tag, "_conv"},      bus.converged_out, 0);
    check({tag, "_iter"},      bus.iter_count_out, 0);
    check({tag, "_rd_en"},     bus.rd_en_out, 0);
    check({tag, "_rd_i"},      bus.rd_i_out, 0);
    check({tag, "_rd_j"},      bus.rd_j_out, 0);
    check({tag, "_rot_p"},     bus.rot_p_out, 0);
    check({tag, "_rot_q"},     bus.rot_q_out, 0);
  endtask

  // Wait for rot_valid or done from the first SCAN cycle, checking the scan
  task automatic wait_event(output int cyc);
    cyc = 1;
    while (!(bus.rot_valid_out || bus.done_out) && cyc < 40) begin
      if (cyc <= P) begin
        check("scan_rd_en", bus.rd_en_out, 1);
        check("scan_rd_i",  bus.rd_i_out, pair_i[cyc-1]);
        check("scan_rd_j",  bus.rd_j_out, pair_j[cyc-1]);
      end else begin
        check("scan_rd_idle", bus.rd_en_out, 0);
      end
      check("scan_busy", bus.busy_out, 1);
      @(posedge clk); #1;
      cyc++;
    end
    check("event_cycle", cyc, P + 3);
  endtask

  // One full run against the model; leaves the bench in the IDLE cycle
  task automatic do_run(input logic [WIDTH-1:0] thr, input bit zero_on_done, input int max_stall);
    logic [W-1:0] pq;
    int cyc, nrot, stall, lat, p, q;
    build_expect(thr, zero_on_done);
    start_run(thr);
    nrot = 0;
    forever begin
      wait_event(cyc);
      if (cyc >= 40) return;
      if (bus.done_out) break;
      check("rot_iter", bus.iter_count_out, nrot);
      check("rot_extra", exp_q.size() > 0, 1);
      if (exp_q.size() == 0) return;
      pq = exp_q.pop_front();
      p  = int'(pq[W-1:AW]);
      q  = int'(pq[AW-1:0]);
      check("rot_p", bus.rot_p_out, p);
      check("rot_q", bus.rot_q_out, q);
      stall = $urandom_range(0, max_stall);
      repeat (stall) begin
        @(posedge clk); #1;
        check("stall_valid", bus.rot_valid_out, 1);
        check("stall_p",     bus.rot_p_out, p);
        check("stall_q",     bus.rot_q_out, q);
      end
      bus.rot_ready_in = 1'b1;
      @(posedge clk); #1;
      bus.rot_ready_in = 1'b0;
      check("hs_valid_drop", bus.rot_valid_out, 0);
      check("hs_busy",       bus.busy_out, 1);
      lat = $urandom_range(0, 3);
      repeat (lat) begin @(posedge clk); #1; end
      if (zero_on_done) set_elem(p, q, 0);
      bus.rot_done_in = 1'b1;
      bus.start_in    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      bus.rot_done_in = 1'b0;
      bus.start_in    = 1'b0;
      nrot++;
    end
    check("done_conv",    bus.converged_out, exp_conv);
    check("done_iter",    bus.iter_count_out, exp_iter);
    check("done_left",    exp_q.size(), 0);
    check("done_busy",    bus.busy_out, 0);
    @(posedge clk); #1;
    check("done_pulse",   bus.done_out, 0);
    check("idle_conv",    bus.converged_out, exp_conv);
    check("idle_iter",    bus.iter_count_out, exp_iter);
  endtask

  task automatic random_mat(input int range);
    for (int i = 0; i < N - 1; i++)
      for (int j = i + 1; j < N; j++)
        set_elem(i, j, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 2 * range) - range);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, bp, bq, bmag, k;
    k = 0;
    for (int i = 0; i < N - 1; i++)
      for (int j = i + 1; j < N; j++) begin
        pair_i[k] = i; pair_j[k] = j; k++;
      end
    rst = 1'b1;
    bus.start_in     = 1'b0;
    bus.threshold_in = '0;
    bus.rot_ready_in = 1'b0;
    bus.rot_done_in  = 1'b0;
    clear_mat();
    #12;
    check_all_zero("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    // zero off-diagonals: converges immediately
    do_run(16'd0, 1'b1, 0);

    // dominant -300 then the two other elements above threshold
    for (int i = 0; i < N - 1; i++)
      for (int j = i + 1; j < N; j++) set_elem(i, j, $urandom_range(0, 100) - 50);
    set_elem(1, 3, -300);
    set_elem(0, 2, 80);
    set_elem(2, 3, -70);
    do_run(16'd50, 1'b1, 0);

    // tie: earlier pair in scan order wins
    clear_mat();
    set_elem(0, 2, 500);
    set_elem(1, 2, 500);
    do_run(16'd0, 1'b1, 2);

    // extreme codes: -32768 outranks 32767
    clear_mat();
    set_elem(0, 1, 32767);
    set_elem(2, 3, -32768);
    do_run(16'd0, 1'b1, 1);

    // threshold boundary on magnitude 0x8000
    clear_mat();
    set_elem(2, 3, -32768);
    do_run(16'h8000, 1'b1, 0);
    do_run(16'h7fff, 1'b1, 0);

    // matrix never changes: rotation budget ends the run
    random_mat(200);
    set_elem(0, 3, 1000);
    do_run(16'd10, 1'b0, 2);

    // stalled request, ignored rot_done, then reset during WAIT
    clear_mat();
    set_elem(0, 1, 40);
    set_elem(1, 3, -900);
    model_m = mat;
    find_pivot(bp, bq, bmag);
    start_run(16'd5);
    wait_event(cyc);
    check("stall_first_valid", bus.rot_valid_out, 1);
    check("stall_first_p", bus.rot_p_out, bp);
    check("stall_first_q", bus.rot_q_out, bq);
    for (int s = 0; s < 5; s++) begin
      bus.rot_done_in = (s == 1);
      @(posedge clk); #1;
      bus.rot_done_in = 1'b0;
      check("hold_valid", bus.rot_valid_out, 1);
      check("hold_p", bus.rot_p_out, bp);
      check("hold_q", bus.rot_q_out, bq);
    end
    check("hold_iter", bus.iter_count_out, 0);
    bus.rot_ready_in = 1'b1;
    @(posedge clk); #1;
    bus.rot_ready_in = 1'b0;
    check("wait_valid", bus.rot_valid_out, 0);
    check("wait_busy", bus.busy_out, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_run(16'd5, 1'b1, 1);

    // randomized runs, each started back-to-back from the IDLE after DONE
    for (int r = 0; r < 10; r++) begin
      random_mat(300);
      do_run(WIDTH'($urandom_range(0, 250)), 1'($urandom_range(0, 1)), 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jacobi_pivot_sequencer.md
# jacobi_pivot_sequencer

Sequential controller for the Jacobi eigen-decomposition of the N_STOCKS×N_STOCKS symmetric covariance matrix. Each iteration it scans the upper triangle of the matrix register file over a registered read port, finds the largest-magnitude off-diagonal element (p,q), and hands (p,q) to the rotation unit over a valid/ready handshake. It repeats until the pivot magnitude is at or below a threshold, or until MAX_ITER rotations have been issued. It sits between the matrix storage and the rotation datapath and owns the iteration count.

## Interface
- WIDTH, 16, matrix element width (signed two's complement)
- N_STOCKS, 4, matrix dimension (≥2); P = N_STOCKS·(N_STOCKS−1)/2 pairs; AW = $clog2(N_STOCKS)
- MAX_ITER, 32, rotation budget per run; CW = $clog2(MAX_ITER+1)

Ports:
- clk_in  in  1  system clock, rising edge
- rst_in  in  1  reset, asynchronous, active-high
- start_in  in  1  begin run; sampled only in IDLE
- threshold_in  in  WIDTH  unsigned convergence bound; latched on accepted start
- rd_en_out  out  1  read request, high only in SCAN address-issue cycles
- rd_i_out, rd_j_out  out  AW  read address (row, col)
- rd_data_in  in  WIDTH  signed matrix[i][j], valid exactly 1 cycle after rd_en_out
- rot_valid_out  out  1  rotation request
- rot_ready_in  in  1  rotation unit accepts request
- rot_p_out, rot_q_out  out  AW  pivot indices, p<q
- rot_done_in  in  1  pulse: rotation written back to matrix storage
- busy_out  out  1  high in SCAN, DECIDE, ROTATE, WAIT
- done_out  out  1  one-cycle pulse at end of run
- converged_out  out  1  run ended on threshold; held until next accepted start
- iter_count_out  out  CW  rotations completed this run

## Operation
- States: IDLE, SCAN, DECIDE, ROTATE, WAIT, DONE.
- IDLE: start_in=1 → latch threshold, clear iter_count, clear converged_out → SCAN.
- SCAN: issue the P addresses row-major on consecutive cycles: (0,1),(0,2)…(0,N−1),(1,2)…(N−2,N−1). Compare each returned datum one cycle later.
  - Magnitude |x| is computed as an unsigned WIDTH-bit value; −2^(WIDTH−1) has magnitude 2^(WIDTH−1), with no saturation.
  - The running maximum starts at 0 with pivot (0,1) and updates only on a strictly greater magnitude, so the earliest pair in scan order wins ties.
  - SCAN lasts P+1 cycles, then goes to DECIDE.
- DECIDE, one cycle:
  - max ≤ threshold → converged_out=1, go to DONE.
  - Otherwise, iter_count == MAX_ITER → converged_out=0, go to DONE.
  - Otherwise register p,q and go to ROTATE.
- ROTATE: rot_valid_out=1. p and q stay stable until rot_valid && rot_ready. At the handshake, rot_valid drops the next cycle and the state goes to WAIT.
- WAIT: on rot_done_in=1, iter_count increments and the state returns to SCAN, which rescans the full triangle.
- DONE: done_out=1 for one cycle, then IDLE.
- rot_done_in is ignored outside WAIT. The earliest legal rot_done is the cycle after the handshake.
- start_in is ignored outside IDLE.
- rd_data_in is ignored outside the SCAN return cycles.

## Timing
- Reset values (applied asynchronously while rst_in=1): state IDLE, all outputs 0, addresses 0, iter_count 0, internal max 0.
- Start accepted at edge 0:
  - SCAN addresses appear in cycles 1..P.
  - Data returns in cycles 2..P+1.
  - DECIDE in cycle P+2.
  - rot_valid_out first high in cycle P+3, or done_out high in cycle P+3.
- N=4 (P=6): rotation request at cycle 9; with zero matrix, done_out at cycle 9.
- Per iteration: P+2 + handshake wait + rotation latency.
- Reset mid-run: the run aborts immediately and rot_valid_out drops asynchronously. The next start runs from scratch.
- Back-to-back runs: start_in may be accepted in the IDLE cycle right after DONE.

## Test plan
- Zero off-diagonals, threshold=0, N=4 → no rot_valid, done_out at cycle 9, converged_out=1, iter_count=0.
- a[1][3]=−300, others |·|≤100, threshold=50, ready tied 1, bench zeros the pivot element on rot_done → first request (1,3), then successive largest elements. Ends converged_out=1 with iter_count = number of off-diagonal elements with |·|>50.
- Tie: a[0][2]=a[1][2]=500, rest 0 → request (0,2).
- a[0][1]=32767, a[2][3]=−32768 → request (2,3).
- Bench never modifies the matrix, MAX_ITER=3 → exactly 3 handshakes, then done_out with converged_out=0 and iter_count=3.
- rot_ready low for 5 cycles → rot_valid and p/q held stable. Then rst_in pulsed during WAIT → all outputs 0 immediately. A new start then reproduces the first request at cycle 9.
